irq_timer: RTL and testbench

Programmable down-counting timer that produces a hardware interrupt request for the coprocessor-0 interrupt input. It sits on the system bridge as a memory-mapped peripheral, written and read by store/load instructions. Its `irq` output drives one bit of the CP0 `hwint` vector. It supports one-shot (mode 0) and auto-reload (mode 1) operation.

---
 rtl/irq_timer.sv | 181 ++++++++++++++++++
 tb/tb_irq_timer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer.sv
// ---------------------------------------------------------------------------
// irq_timer
//
// Memory-mapped down-counting timer that raises an interrupt request for one
// bit of the CP0 hwint vector. Software programs a reload value (PRESET) and
// a control word (CTRL); the timer loads COUNT from PRESET, counts down to
// zero and then enters an interrupt state. It runs in one of two modes:
//   mode 1     : auto-reload, irq pulses for one cycle every period
//   mode 0/2/3 : one-shot, EN is cleared on reaching zero and irq stays high
//                until software re-enables, masks, or resets the timer
//
// Register map (decoded from addr[3:2]):
//   0 CTRL   {28'b0, IM, MODE[1:0], EN}   read/write
//   1 PRESET reload value                 read/write
//   2 COUNT  current count                read-only
//   3 -      reads 0, writes ignored
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset, clears every register
//   addr     bridge byte address (only bits [3:2] decoded)
//   we       write strobe, sampled on the rising edge
//   din      write data
//   dout     combinational read data for the addressed register
//   irq      interrupt request, (state == INT) & IM
// ---------------------------------------------------------------------------
module irq_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_t      state;
  state_t      next_state;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;

  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        auto_reload;
  logic        count_zero;

  logic [1:0]  reg_sel;
  logic        ctrl_wr;
  logic        preset_wr;

  logic        load_count;
  logic        dec_count;
  logic        hw_en_clear;

  // Only addr[3:2] selects a register; the remaining address bits are
  // folded into a named sink so they are visibly and deliberately ignored.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  // Field decode of the control word and of the bus access.
  assign en          = ctrl[0];
  assign mode        = ctrl[2:1];
  assign im          = ctrl[3];
  assign auto_reload = (mode == MODE_RELOAD);
  assign count_zero  = (count == 32'd0);

  assign reg_sel     = addr[3:2];
  assign ctrl_wr     = we && (reg_sel == ADDR_CTRL);
  assign preset_wr   = we && (reg_sel == ADDR_PRESET);

  // State register. Reset forces IDLE immediately, without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. All decisions use the registered EN, so a software
  // CTRL write takes effect on the edge after the one that wrote it.
  // In one-shot INT the hardware has already cleared EN, so the timer waits
  // there until software writes EN=1 again.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (en) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = en ? CNT : IDLE;
      end
      CNT: begin
        if (!en) begin
          next_state = IDLE;
        end else if (count_zero) begin
          next_state = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          next_state = en ? LOAD : IDLE;
        end else begin
          next_state = en ? LOAD : INT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output and datapath-control decode from the registered state.
  // The decrement stops at zero so COUNT can never wrap, and the one-shot
  // EN clear is issued exactly on the edge that enters INT.
  always_comb begin
    load_count  = (state == LOAD);
    dec_count   = (state == CNT) && en && !count_zero;
    hw_en_clear = (state == CNT) && en && count_zero && !auto_reload;
    irq         = (state == INT) && im;
  end

  // Software-visible registers. A software CTRL write on the same edge as
  // the hardware EN clear overrides it, so a re-enable is never lost.
  // PRESET only reaches COUNT through LOAD, so rewriting PRESET while
  // counting affects the next period, not the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= din[3:0];
      end else if (hw_en_clear) begin
        ctrl[0] <= 1'b0;
      end

      if (preset_wr) begin
        preset <= din;
      end

      if (load_count) begin
        count <= preset;
      end else if (dec_count) begin
        count <= count - 32'd1;
      end
    end
  end

  // Read mux. Purely combinational from the address, so a read sees a
  // register update in the cycle after the edge that wrote it.
  always_comb begin
    dout = 32'd0;
    case (reg_sel)
      ADDR_CTRL:   dout = {28'd0, ctrl};
      ADDR_PRESET: dout = preset;
      ADDR_COUNT:  dout = count;
      default:     dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_timer.sv
// ---------------------------------------------------------------------------
// tb_irq_timer
//
// Directed bench for irq_timer. Each step drives the bus, pushes the value
// the timer should show onto a scoreboard queue, then samples the DUT one
// time unit after the clock edge and pops the expectation for comparison.
// Edge numbering in the tags follows the enable latency: E0 is the edge that
// writes CTRL with EN=1.
// ---------------------------------------------------------------------------
module tb_irq_timer;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_NONE   = 2'd3;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  irq_timer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq     (irq)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against any unexpected stall of the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the end of the test sequence");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus write: strobe held across exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a, 2'b00};
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    din  = 32'd0;
  endtask

  // Queue the value the next observation must match.
  task automatic pushExpect(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows.
  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expectReg(input string tag, input logic [1:0] a, input logic [31:0] val);
    pushExpect(tag, val);
    addr = {28'd0, a, 2'b00};
    #1;
    checkOutput(dout);
  endtask

  task automatic expectIrq(input string tag, input logic val);
    pushExpect(tag, {31'd0, val});
    checkOutput({31'd0, irq});
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_count;
    logic        exp_irq;
    int          p;

    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    we      = 1'b0;
    addr    = 32'd0;
    din     = 32'd0;

    // ---------------- reset values ----------------
    tick();
    tick();
    expectReg("rst_ctrl",   A_CTRL,   32'd0);
    expectReg("rst_preset", A_PRESET, 32'd0);
    expectReg("rst_count",  A_COUNT,  32'd0);
    expectReg("rst_addr3",  A_NONE,   32'd0);
    expectIrq("rst_irq", 1'b0);
    reset_n = 1'b1;
    tick();

    // ---------------- mode 0, PRESET=5 ----------------
    $display("[TB] mode 0 one-shot, PRESET=5");
    applyStimulus(A_PRESET, 32'd5);
    applyStimulus(A_CTRL, 32'hFFFF_FFF9);
    expectReg("m0_ctrl_E0",   A_CTRL,   32'h9);
    expectReg("m0_preset_E0", A_PRESET, 32'd5);
    expectReg("m0_count_E0",  A_COUNT,  32'd0);
    tick();
    expectReg("m0_count_E1", A_COUNT, 32'd0);
    tick();
    expectReg("m0_count_E2", A_COUNT, 32'd5);
    expectIrq("m0_irq_E2", 1'b0);
    for (int k = 3; k <= 7; k++) begin
      tick();
      expectReg($sformatf("m0_count_E%0d", k), A_COUNT, 32'(7 - k));
      expectIrq($sformatf("m0_irq_E%0d", k), 1'b0);
    end
    tick();
    expectIrq("m0_irq_E8", 1'b1);
    expectReg("m0_ctrl_E8",  A_CTRL,  32'h8);
    expectReg("m0_count_E8", A_COUNT, 32'd0);
    for (int k = 9; k <= 11; k++) begin
      tick();
      expectIrq($sformatf("m0_irq_hold_E%0d", k), 1'b1);
    end

    // ---------------- mask in INT, re-enable wins ----------------
    $display("[TB] mask and re-enable from one-shot INT");
    applyStimulus(A_CTRL, 32'h1);
    expectIrq("mask_irq_drop", 1'b0);
    expectReg("mask_ctrl", A_CTRL, 32'h1);
    tick();
    expectReg("mask_count_load", A_COUNT, 32'd0);
    tick();
    expectReg("mask_count_reload", A_COUNT, 32'd5);
    expectIrq("mask_irq_cnt", 1'b0);
    tick();
    expectReg("mask_count_dec", A_COUNT, 32'd4);

    // ---------------- asynchronous reset mid-count ----------------
    $display("[TB] asynchronous reset mid-count");
    reset_n = 1'b0;
    #1;
    expectReg("arst_count",  A_COUNT,  32'd0);
    expectReg("arst_ctrl",   A_CTRL,   32'd0);
    expectReg("arst_preset", A_PRESET, 32'd0);
    expectIrq("arst_irq", 1'b0);
    #2;
    reset_n = 1'b1;
    applyStimulus(A_PRESET, 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      expectReg($sformatf("arst_idle_count_%0d", k), A_COUNT, 32'd0);
      expectIrq($sformatf("arst_idle_irq_%0d", k), 1'b0);
    end

    // ---------------- mode 1, PRESET=3 ----------------
    $display("[TB] mode 1 auto-reload, PRESET=3");
    applyStimulus(A_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 1) begin
        exp_count = 32'd0;
        exp_irq   = 1'b0;
      end else begin
        p         = (k - 2) % 6;
        exp_count = (p <= 3) ? 32'(3 - p) : 32'd0;
        exp_irq   = (p == 4);
      end
      expectReg($sformatf("m1_count_E%0d", k), A_COUNT, exp_count);
      expectIrq($sformatf("m1_irq_E%0d", k), exp_irq);
    end
    expectReg("m1_ctrl", A_CTRL, 32'hB);

    // ---------------- PRESET=0 ----------------
    $display("[TB] PRESET=0");
    doReset();
    applyStimulus(A_PRESET, 32'd0);
    applyStimulus(A_CTRL, 32'h9);
    tick();
    expectIrq("p0_irq_E1", 1'b0);
    tick();
    expectIrq("p0_irq_E2", 1'b0);
    expectReg("p0_count_E2", A_COUNT, 32'd0);
    tick();
    expectIrq("p0_irq_E3", 1'b1);
    expectReg("p0_ctrl_E3", A_CTRL, 32'h8);

    // ---------------- software write on the INT entry edge ----------------
    $display("[TB] CTRL write coincident with hardware EN clear");
    doReset();
    applyStimulus(A_CTRL, 32'h9);
    tick();
    tick();
    applyStimulus(A_CTRL, 32'h9);
    expectIrq("coinc_irq_E3", 1'b1);
    expectReg("coinc_ctrl_E3", A_CTRL, 32'h9);
    tick();
    expectIrq("coinc_irq_E4", 1'b0);
    tick();
    tick();
    expectIrq("coinc_irq_E6", 1'b1);
    expectReg("coinc_ctrl_E6", A_CTRL, 32'h8);

    // ---------------- PRESET rewritten during CNT ----------------
    $display("[TB] PRESET 10 -> 2 while counting");
    doReset();
    applyStimulus(A_PRESET, 32'd10);
    applyStimulus(A_CTRL, 32'hB);
    tick();
    tick();
    expectReg("pw_count_E2", A_COUNT, 32'd10);
    tick();
    expectReg("pw_count_E3", A_COUNT, 32'd9);
    applyStimulus(A_PRESET, 32'd2);
    expectReg("pw_count_E4",  A_COUNT,  32'd8);
    expectReg("pw_preset_E4", A_PRESET, 32'd2);
    for (int k = 5; k <= 18; k++) begin
      tick();
      if (k <= 12)      exp_count = 32'(12 - k);
      else if (k <= 14) exp_count = 32'd0;
      else if (k <= 16) exp_count = 32'(17 - k);
      else              exp_count = 32'd0;
      exp_irq = (k == 13) || (k == 18);
      expectReg($sformatf("pw_count_E%0d", k), A_COUNT, exp_count);
      expectIrq($sformatf("pw_irq_E%0d", k), exp_irq);
    end

    // ---------------- disable mid-count, ignored writes, re-enable ----------------
    $display("[TB] disable at COUNT=7, then re-enable");
    doReset();
    applyStimulus(A_PRESET, 32'd10);
    applyStimulus(A_CTRL, 32'h1);
    tick();
    tick();
    tick();
    tick();
    expectReg("dis_count_E4", A_COUNT, 32'd8);
    applyStimulus(A_CTRL, 32'h0);
    expectReg("dis_count_E5", A_COUNT, 32'd7);
    tick();
    expectReg("dis_count_idle", A_COUNT, 32'd7);
    applyStimulus(A_COUNT, 32'h1234);
    expectReg("dis_count_wr_ignored", A_COUNT, 32'd7);
    applyStimulus(A_NONE, 32'hFFFF_FFFF);
    expectReg("dis_addr3",  A_NONE,   32'd0);
    expectReg("dis_ctrl",   A_CTRL,   32'd0);
    expectReg("dis_preset", A_PRESET, 32'd10);
    expectReg("dis_count",  A_COUNT,  32'd7);
    tick();
    expectReg("dis_count_hold", A_COUNT, 32'd7);
    expectIrq("dis_irq", 1'b0);
    applyStimulus(A_CTRL, 32'h1);
    expectReg("reen_count_Er", A_COUNT, 32'd7);
    tick();
    expectReg("reen_count_load", A_COUNT, 32'd7);
    tick();
    expectReg("reen_count_reload", A_COUNT, 32'd10);

    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover remaining=%0d required=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
